// File: rtl/pila_n_if.sv
// pila_n_if: request/response bundle between the PC path and the return-address stack.
// The error ports (clr_err, ovf, unf) exist only when PILA_N_ERR_EN is defined.
interface pila_n_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] inpush;
  logic [WIDTH-1:0] outpop;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
`ifdef PILA_N_ERR_EN
  logic             clr_err;
  logic             ovf;
  logic             unf;

  modport master (
    output push, pop, inpush, clr_err,
    input  outpop, count, empty, full, ovf, unf
  );

  modport slave (
    input  push, pop, inpush, clr_err,
    output outpop, count, empty, full, ovf, unf
  );
`else
  modport master (
    output push, pop, inpush,
    input  outpop, count, empty, full
  );

  modport slave (
    input  push, pop, inpush,
    output outpop, count, empty, full
  );
`endif
endinterface

// File: rtl/pila_n.sv
// pila_n: parametrised return-address stack with replace-top and saturating pointer.
// Optional sticky overflow/underflow flags are built when PILA_N_ERR_EN is defined.
module pila_n #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  pila_n_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [CW-1:0]    sp_nxt;
  logic [CW-1:0]    sp_dec;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             is_empty;
  logic             is_full;
  logic             do_push;
  logic             do_pop;
  logic             do_repl;
  logic             wr_en;

  // sp equals the occupancy, so all status is a pure decode of it
  assign is_empty = (sp == '0);
  assign is_full  = (sp == FULL_CNT);
  assign sp_dec   = sp - CW'(1);
  assign top_idx  = sp_dec[AW-1:0];

  // Request decode; overflow pushes and underflow pops fall through as no-ops
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_repl = 1'b0;
    case ({bus.push, bus.pop})
      2'b10: do_push = !is_full;
      2'b01: do_pop  = !is_empty;
      2'b11: begin
        do_repl = !is_empty;
        do_push = is_empty;
      end
      default: ;
    endcase
  end

  assign wr_en  = do_push | do_repl;
  assign wr_idx = do_repl ? top_idx : sp[AW-1:0];

  // Next pointer; saturation comes from the decode never requesting past 0 or DEPTH
  always_comb begin
    sp_nxt = sp;
    if (do_push)
      sp_nxt = sp + CW'(1);
    else if (do_pop)
      sp_nxt = sp_dec;
  end

  // Stack pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sp <= '0;
    else
      sp <= sp_nxt;
  end

  // Entry storage is not reset; writes are gated while reset is held
  always_ff @(posedge clk) begin
    if (reset && wr_en)
      mem[wr_idx] <= bus.inpush;
  end

  assign bus.outpop = is_empty ? '0 : mem[top_idx];
  assign bus.count  = sp;
  assign bus.empty  = is_empty;
  assign bus.full   = is_full;

`ifdef PILA_N_ERR_EN
  logic ovf_evt;
  logic unf_evt;
  logic ovf_q;
  logic unf_q;

  assign ovf_evt = bus.push & ~bus.pop & is_full;
  assign unf_evt = bus.pop & ~bus.push & is_empty;

  // Sticky error flags; a same-cycle event takes priority over clr_err
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_evt)
        ovf_q <= 1'b1;
      else if (bus.clr_err)
        ovf_q <= 1'b0;
      if (unf_evt)
        unf_q <= 1'b1;
      else if (bus.clr_err)
        unf_q <= 1'b0;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
`endif
endmodule

// File: doc/pila_n.md
# pila_n

Parametrised, fully synchronous hardware return-address stack for the CPU's subroutine and interrupt call path. It is the next generation of the 8-entry pila. It adds configurable width and depth, a simultaneous push/pop (replace-top) mode, occupancy and full/empty status, and optional sticky overflow/underflow error flags. It sits between the PC next-address mux and the PC register: call and interrupt entry push the return address, and return pops it.

## Interface
- WIDTH, 10, bit width of each stored entry (PC width).
- DEPTH, 8, number of entries. Must be a power of two, ≥2.
- Localparam AW = $clog2(DEPTH), the pointer width.
- Localparam CW = $clog2(DEPTH+1), the count width.

- clk  in  1  clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  push request, sampled on rising clk.
- pop  in  1  pop request, sampled on rising clk.
- inpush  in  WIDTH  data to push.
- outpop  out  WIDTH  current top-of-stack entry; 0 when empty.
- count  out  CW  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- clr_err  in  1  synchronous clear of ovf/unf. Present only with PILA_N_ERR_EN.
- ovf  out  1  sticky overflow flag. Present only with PILA_N_ERR_EN.
- unf  out  1  sticky underflow flag. Present only with PILA_N_ERR_EN.

## Operation
- Storage: DEPTH×WIDTH register array plus pointer sp (AW+1 bits, equal to count). Array contents are not reset.
- outpop is combinational: mem[sp-1] when sp≠0, else 0. A consumer samples outpop in the same cycle it asserts pop.
- Per rising clk, decided on {push,pop} and state:
  - 00: hold.
  - 10, not full: mem[sp]←inpush; sp←sp+1.
  - 10, full: dropped; sp unchanged; ovf←1.
  - 01, not empty: sp←sp−1; entry stays in the array but is no longer visible.
  - 01, empty: ignored; sp stays 0; unf←1.
  - 11, not empty: replace top, mem[sp-1]←inpush; sp unchanged. This covers full as well; no ovf.
  - 11, empty: behaves as push 10; no unf.
- sp never wraps: it saturates at 0 and DEPTH.
- clr_err clears ovf and unf. If an error event occurs in the same cycle as clr_err, the event wins and the flag is set.
- No internal state machine beyond sp. The status outputs are decoded from sp.

## Timing
- Reset (reset=0, asynchronous): sp=0 immediately, so count=0, empty=1, full=0, outpop=0, ovf=0, unf=0.
- Reset asserted mid-operation aborts any pending update.
- Release of reset is synchronous to the next rising clk. The first push is accepted on the first rising edge with reset=1.
- Push latency: 1 cycle. The pushed value appears on outpop, and count increments, after the capturing edge.
- Pop: outpop carries the popped value during the cycle pop is high. After the edge, outpop shows the next entry, or 0.
- Replace-top: the new value is on outpop after the edge; count is unchanged.
- Flags update on the same edge as the event that sets them.
- No combinational path from push/pop to any output.

## Configuration
- PILA_N_ERR_EN defined: ports clr_err, ovf and unf exist and behave as above.
- PILA_N_ERR_EN undefined: those ports and their flops are removed. Overflow pushes and underflow pops are still silently ignored, with identical sp behaviour.

## Test plan
All scenarios use WIDTH=10, DEPTH=8, PILA_N_ERR_EN defined.
- Reset: hold reset=0, push=1 for 3 clk; release -> count=0, empty=1, outpop=0, ovf=unf=0 throughout.
- Fill/drain: push 0x001..0x008 on 8 edges -> full=1, count=8, outpop=0x008. Then pop 8 times -> outpop sequence 0x008..0x001 sampled in pop cycles, ending with empty=1, outpop=0.
- Overflow: when full, push 0x3FF -> count stays 8, outpop stays 0x008, ovf=1. Next cycle clr_err=1 -> ovf=0.
- Underflow: when empty, pop -> count=0, unf=1. Then push 0x155 and pop together on an empty stack -> count=1, outpop=0x155, unf stays 1 until cleared.
- Replace-top: stack holds 0x010, 0x020. Push 0x0AA with pop -> count=2, outpop=0x0AA. A subsequent pop leaves outpop=0x010.
- Async reset mid-op: with 5 entries, drive reset=0 between edges -> count=0, empty=1, outpop=0 with no clk edge. After release, push 0x2C3 -> outpop=0x2C3, count=1.
